dpad_repeat_encoder: RTL and testbench

- Front end for the box/piece movement logic: conditions four raw push-buttons into the one-hot `up`/`down`/`left`/`right` direction strobes that the movement state machine samples.
- Per-button flow: 2-flop synchronise, debounce, priority-encode to one direction, then emit a fixed-width pulse on press.
- Holding a button auto-repeats the pulse, so a held direction keeps the object moving at a controlled rate instead of one step per press.

---
 rtl/dpad_repeat_encoder.sv | 141 ++++++++++++++
 tb/tb_dpad_repeat_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpad_repeat_encoder.sv
// rtl/dpad_repeat_encoder.sv - debounced, priority-encoded d-pad direction strobes with auto-repeat
module dpad_repeat_encoder #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PULSE_CYCLES    = 16777216,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 8000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       rpt,
   output logic [7:0] pulse_count
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int T1   = (PULSE_CYCLES > REPEAT_DELAY) ? PULSE_CYCLES : REPEAT_DELAY;
   localparam int TMAX = (T1 > REPEAT_PERIOD) ? T1 : REPEAT_PERIOD;
   localparam int CW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, FIRE, WAIT} state_t;

   logic [3:0]         raw, sync1, sync2, db;
   logic [3:0][DW-1:0] db_cnt;
   state_t             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               rpt_flag_q, rpt_flag_d;
   logic [3:0]         dir_q;
   logic               rpt_q;

   assign raw = {btn_right, btn_left, btn_down, btn_up};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db     <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   function automatic logic [1:0] prio(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // One shared down-counter times both the pulse and the repeat gap.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      rpt_flag_d = rpt_flag_q;
      case (state_q)
         IDLE: begin
            if (db != 4'b0000) begin
               sel_d      = prio(db);
               cnt_d      = CW'(PULSE_CYCLES);
               rpt_flag_d = 1'b0;
               state_d    = FIRE;
            end
         end
         FIRE: begin
            if (cnt_q == CW'(1)) begin
               if (db[sel_q]) begin
                  state_d = WAIT;
                  cnt_d   = rpt_flag_q ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WAIT: begin
            if (!db[sel_q]) begin
               state_d = IDLE;
            end else if (cnt_q == CW'(1)) begin
               rpt_flag_d = 1'b1;
               cnt_d      = CW'(PULSE_CYCLES);
               state_d    = FIRE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= 2'd0;
         cnt_q       <= '0;
         rpt_flag_q  <= 1'b0;
         dir_q       <= 4'b0000;
         rpt_q       <= 1'b0;
         pulse_count <= 8'd0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         rpt_flag_q <= rpt_flag_d;
         dir_q      <= (state_d == FIRE) ? (4'b0001 << sel_d) : 4'b0000;
         rpt_q      <= (state_d == FIRE) && rpt_flag_d;
         if (state_d == FIRE && state_q != FIRE)
            pulse_count <= pulse_count + 8'd1;
      end
   end

   assign {right, left, down, up} = dir_q;
   assign rpt = rpt_q;

endmodule

// File: tb/tb_dpad_repeat_encoder.sv
// tb/tb_dpad_repeat_encoder.sv - table, directed and randomized checks of dpad_repeat_encoder
module tb_dpad_repeat_encoder;
   localparam int DEB  = 4;
   localparam int PUL  = 3;
   localparam int DEL  = 10;
   localparam int PER  = 5;
   localparam int MAXN = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       up, down, left, right, rpt;
   logic [7:0] pulse_count;

   dpad_repeat_encoder #(
      .DEBOUNCE_CYCLES(DEB),
      .PULSE_CYCLES   (PUL),
      .REPEAT_DELAY   (DEL),
      .REPEAT_PERIOD  (PER)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .rpt        (rpt),
      .pulse_count(pulse_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [3:0] raw_tr  [MAXN];
   logic [3:0] lvl_m   [MAXN];
   logic [3:0] exp_dir [MAXN];
   logic       exp_rpt [MAXN];
   logic [7:0] exp_cnt [MAXN];
   bit         fire_m  [MAXN];
   logic [3:0] obs_dir [MAXN];
   logic       obs_rpt [MAXN];
   logic [7:0] obs_cnt [MAXN];
   int         model_len;

   typedef struct {
      logic [3:0] mask;
      int         hold;
      int         edge_no;
      logic [3:0] dir;
      logic       rpt;
      logic [7:0] cnt;
   } vec_t;
   vec_t tbl[15];

   task automatic check(input string name, input int edge_no, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_no, act, req);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic apply_edge(input logic [3:0] r, output logic [3:0] d, output logic rp, output logic [7:0] c);
      {btn_right, btn_left, btn_down, btn_up} = r;
      @(posedge clk);
      #1;
      d  = {right, left, down, up};
      rp = rpt;
      c  = pulse_count;
   endtask

   task automatic run_trace(input int len);
      do_reset();
      for (int n = 0; n < len; n++)
         apply_edge(raw_tr[n], obs_dir[n], obs_rpt[n], obs_cnt[n]);
   endtask

   function automatic logic sync_at(input int k, input int b);
      if (k < 2) return 1'b0;
      return raw_tr[k-2][b];
   endfunction

   function automatic logic held(input int k, input int sel);
      if (k < 0 || k >= model_len) return 1'b0;
      return lvl_m[k][sel];
   endfunction

   function automatic int prio_of(input logic [3:0] v);
      for (int b = 0; b < 4; b++)
         if (v[b]) return b;
      return 0;
   endfunction

   // Debounced levels from a sliding-window rule, then a pulse/gap schedule on top.
   task automatic build_model(input int len);
      int    n, e, sel, gap, nxt, cnt;
      bit    rptf, active;
      logic  cur;
      int    last;
      bit    flip;
      model_len = len;
      for (int i = 0; i < len; i++) begin
         exp_dir[i] = 4'b0000;
         exp_rpt[i] = 1'b0;
         fire_m[i]  = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
         cur  = 1'b0;
         last = -DEB;
         for (int t = 0; t < len; t++) begin
            flip = (t - last >= DEB);
            for (int k = t - DEB + 1; k <= t; k++)
               if (sync_at(k, b) == cur) flip = 1'b0;
            if (flip) begin
               cur  = ~cur;
               last = t;
            end
            lvl_m[t][b] = cur;
         end
      end
      n = 0;
      while (n < len) begin
         if (n == 0 || lvl_m[n-1] == 4'b0000) begin
            n++;
         end else begin
            sel    = prio_of(lvl_m[n-1]);
            rptf   = 1'b0;
            active = 1'b1;
            while (active) begin
               if (n < len) fire_m[n] = 1'b1;
               for (int p = 0; p < PUL; p++)
                  if (n + p < len) begin
                     exp_dir[n+p] = 4'b0001 << sel;
                     exp_rpt[n+p] = rptf;
                  end
               e = n + PUL;
               if (!held(e - 1, sel)) begin
                  n      = e + 1;
                  active = 1'b0;
               end else begin
                  gap = rptf ? PER : DEL;
                  nxt = e + gap;
                  for (int j = gap; j >= 1; j--)
                     if (!held(e + j - 1, sel)) nxt = -(e + j + 1);
                  if (nxt < 0) begin
                     n      = -nxt;
                     active = 1'b0;
                  end else begin
                     n    = nxt;
                     rptf = 1'b1;
                  end
               end
               if (n >= len) active = 1'b0;
            end
         end
      end
      cnt = 0;
      for (int i = 0; i < len; i++) begin
         if (fire_m[i]) cnt++;
         exp_cnt[i] = 8'(cnt % 256);
      end
   endtask

   task automatic model_compare(input int len);
      build_model(len);
      for (int n = 0; n < len; n++) begin
         check("model_dir", n, 8'(obs_dir[n]), 8'(exp_dir[n]));
         check("model_rpt", n, 8'(obs_rpt[n]), 8'(exp_rpt[n]));
         check("model_cnt", n, obs_cnt[n], exp_cnt[n]);
      end
   endtask

   initial begin
      logic [3:0] d;
      logic       rp;
      logic [7:0] c;
      logic       lv;

      tbl[0]  = '{4'b0100,  8,  5, 4'b0000, 1'b0, 8'd0};
      tbl[1]  = '{4'b0100,  8,  6, 4'b0100, 1'b0, 8'd1};
      tbl[2]  = '{4'b0100,  8,  8, 4'b0100, 1'b0, 8'd1};
      tbl[3]  = '{4'b0100,  8,  9, 4'b0000, 1'b0, 8'd1};
      tbl[4]  = '{4'b0100,  8, 25, 4'b0000, 1'b0, 8'd1};
      tbl[5]  = '{4'b1000, 40,  6, 4'b1000, 1'b0, 8'd1};
      tbl[6]  = '{4'b1000, 40, 18, 4'b0000, 1'b0, 8'd1};
      tbl[7]  = '{4'b1000, 40, 19, 4'b1000, 1'b1, 8'd2};
      tbl[8]  = '{4'b1000, 40, 21, 4'b1000, 1'b1, 8'd2};
      tbl[9]  = '{4'b1000, 40, 22, 4'b0000, 1'b0, 8'd2};
      tbl[10] = '{4'b1000, 40, 26, 4'b0000, 1'b0, 8'd2};
      tbl[11] = '{4'b1000, 40, 27, 4'b1000, 1'b1, 8'd3};
      tbl[12] = '{4'b1000, 40, 30, 4'b0000, 1'b0, 8'd3};
      tbl[13] = '{4'b0011, 20,  6, 4'b0001, 1'b0, 8'd1};
      tbl[14] = '{4'b0011, 20,  8, 4'b0001, 1'b0, 8'd1};

      for (int i = 0; i < 15; i++) begin
         for (int n = 0; n < 45; n++)
            raw_tr[n] = (n < tbl[i].hold) ? tbl[i].mask : 4'b0000;
         run_trace(45);
         check("tbl_dir", tbl[i].edge_no, 8'(obs_dir[tbl[i].edge_no]), 8'(tbl[i].dir));
         check("tbl_rpt", tbl[i].edge_no, 8'(obs_rpt[tbl[i].edge_no]), 8'(tbl[i].rpt));
         check("tbl_cnt", tbl[i].edge_no, obs_cnt[tbl[i].edge_no], tbl[i].cnt);
      end

      // bounce rejection
      for (int n = 0; n < 40; n++)
         raw_tr[n] = (n < 20 && ((n / 2) % 2 == 0)) ? 4'b0001 : 4'b0000;
      run_trace(40);
      for (int n = 0; n < 40; n++) begin
         check("bounce_dir", n, 8'(obs_dir[n]), 8'h00);
         check("bounce_cnt", n, obs_cnt[n], 8'h00);
      end
      model_compare(40);

      // priority, then lower-priority button after up is released
      for (int n = 0; n < 40; n++)
         raw_tr[n] = {2'b00, 1'b1, (n < 10)};
      run_trace(40);
      check("prio_up", 6, 8'(obs_dir[6]), 8'h01);
      check("prio_gap", 16, 8'(obs_dir[16]), 8'h00);
      check("prio_down", 17, 8'(obs_dir[17]), 8'h02);
      check("prio_cnt", 17, obs_cnt[17], 8'd2);
      for (int n = 0; n < 40; n++)
         check("onehot", n, 8'($countones(obs_dir[n]) > 1), 8'h00);
      model_compare(40);

      // release mid-pulse
      for (int n = 0; n < 30; n++)
         raw_tr[n] = (n < 7) ? 4'b0010 : 4'b0000;
      run_trace(30);
      for (int n = 6; n < 9; n++)
         check("midrel_high", n, 8'(obs_dir[n]), 8'h02);
      for (int n = 9; n < 30; n++)
         check("midrel_low", n, 8'(obs_dir[n]), 8'h00);
      check("midrel_cnt", 29, obs_cnt[29], 8'd1);
      model_compare(30);

      // asynchronous reset during a pulse
      do_reset();
      for (int n = 0; n < 8; n++)
         apply_edge(4'b1000, d, rp, c);
      check("rst_pre_dir", 7, 8'(d), 8'h08);
      #2 rst = 1'b1;
      #1;
      check("rst_async_dir", 7, 8'({right, left, down, up}), 8'h00);
      check("rst_async_cnt", 7, pulse_count, 8'h00);
      lv = rpt;
      check("rst_async_rpt", 7, 8'(lv), 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 7; n++) begin
         apply_edge(4'b1000, d, rp, c);
         if (n == 5) check("rst_redeb_low", n, 8'(d), 8'h00);
         if (n == 6) begin
            check("rst_redeb_high", n, 8'(d), 8'h08);
            check("rst_redeb_cnt", n, c, 8'd1);
         end
      end

      // randomized button activity against the reference model
      for (int t = 0; t < 8; t++) begin
         for (int n = 0; n < 300; n++) raw_tr[n] = 4'b0000;
         for (int b = 0; b < 4; b++) begin
            int n, run;
            logic lvl;
            n   = 0;
            lvl = $urandom_range(0, 1);
            while (n < 300) begin
               run = (lvl == 1'b1) ? $urandom_range(1, 45) : $urandom_range(1, 25);
               for (int r = 0; r < run && n < 300; r++) begin
                  raw_tr[n][b] = lvl;
                  n++;
               end
               lvl = ~lvl;
            end
         end
         run_trace(300);
         model_compare(300);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
